// File: rtl/mips_cpu_pc_unit.sv
// Program counter and control-flow sequencer for the Harvard MIPS core.
// Applies branches and jumps after one delay slot; halts on a transfer to HALT_ADDR.
module mips_cpu_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [31:0] HALT_ADDR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump_imm,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] jump_reg_value,
  output logic [31:0] instr_address,
  output logic [31:0] link_address,
  output logic        active,
  output logic        in_delay_slot
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SLOT = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        advance;
  logic        request;

  assign pc_plus4 = pc_q + 32'd4;
  assign advance  = clk_enable && !stall && (state_q != ST_HALT);
  assign request  = branch_taken || jump_imm || jump_reg;

  // Target selection: jump_reg outranks jump_imm, which outranks a branch.
  always_comb begin
    target = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    if (jump_reg) begin
      target = jump_reg_value;
    end else if (jump_imm) begin
      target = {pc_plus4[31:28], jump_index, 2'b00};
    end
  end

  always_comb begin
    pc_d      = pc_q;
    state_d   = state_q;
    pending_d = pending_q;
    if (advance) begin
      case (state_q)
        ST_RUN: begin
          pc_d = pc_plus4;
          if (request) begin
            pending_d = target;
            state_d   = ST_SLOT;
          end
        end
        // Requests seen while in the slot are dropped: the first target wins.
        ST_SLOT: begin
          pc_d    = pending_q;
          state_d = (pending_q == HALT_ADDR) ? ST_HALT : ST_RUN;
        end
        default: begin
          pc_d = pc_q;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_VECTOR;
      state_q   <= ST_RUN;
      pending_q <= 32'd0;
    end else begin
      pc_q      <= pc_d;
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  assign instr_address = pc_q;
  assign link_address  = pc_q + 32'd8;
  assign active        = (state_q != ST_HALT);
  assign in_delay_slot = (state_q == ST_SLOT);

endmodule

// File: tb/tb_mips_cpu_pc_unit.sv
// Self-checking bench for mips_cpu_pc_unit: scenario tasks push expected PC state
// into a scoreboard queue, clock the DUT, then pop and compare.
module tb_mips_cpu_pc_unit;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump_imm;
  logic [25:0] jump_index;
  logic        jump_reg;
  logic [31:0] jump_reg_value;
  logic [31:0] instr_address;
  logic [31:0] link_address;
  logic        active;
  logic        in_delay_slot;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        ce;
    logic        st;
    logic        br;
    logic [15:0] off;
    logic        ji;
    logic [25:0] idx;
    logic        jr;
    logic [31:0] val;
    logic [31:0] pc;
    logic        act;
    logic        slot;
  } step_t;

  step_t sb[$];

  mips_cpu_pc_unit dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_offset  (branch_offset),
    .jump_imm       (jump_imm),
    .jump_index     (jump_index),
    .jump_reg       (jump_reg),
    .jump_reg_value (jump_reg_value),
    .instr_address  (instr_address),
    .link_address   (link_address),
    .active         (active),
    .in_delay_slot  (in_delay_slot)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic step_t mk(input logic ce, input logic st, input logic br,
                               input logic [15:0] off, input logic ji,
                               input logic [25:0] idx, input logic jr,
                               input logic [31:0] val, input logic [31:0] pc,
                               input logic act, input logic slot);
    step_t s;
    s.ce = ce; s.st = st; s.br = br; s.off = off; s.ji = ji; s.idx = idx;
    s.jr = jr; s.val = val; s.pc = pc; s.act = act; s.slot = slot;
    return s;
  endfunction

  function automatic step_t nop(input logic [31:0] pc, input logic slot);
    return mk(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, pc, 1'b1, slot);
  endfunction

  task automatic apply(input step_t s);
    clk_enable     = s.ce;
    stall          = s.st;
    branch_taken   = s.br;
    branch_offset  = s.off;
    jump_imm       = s.ji;
    jump_index     = s.idx;
    jump_reg       = s.jr;
    jump_reg_value = s.val;
  endtask

  task automatic idle_inputs();
    apply(nop(32'h0, 1'b0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    #2;
    compared++;
    if ({instr_address, link_address, active, in_delay_slot} !== {RV, RV + 32'd8, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_async: pc=%h link=%h active=%b slot=%b, expected pc=%h link=%h active=1 slot=0",
               instr_address, link_address, active, in_delay_slot, RV, RV + 32'd8);
    end
    tick();
    compared++;
    if ({instr_address, active, in_delay_slot} !== {RV, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_held: pc=%h active=%b slot=%b, expected pc=%h active=1 slot=0",
               instr_address, active, in_delay_slot, RV);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    step_t t[$];
    step_t e;
    do_reset();
    for (int k = 1; k <= 3; k++) t.push_back(nop(RV + 32'(4 * k), 1'b0));
    foreach (t[i]) begin
      apply(t[i]);
      sb.push_back(t[i]);
      tick();
      e = sb.pop_front();
      compared++;
      if ({instr_address, link_address, active, in_delay_slot} !== {e.pc, e.pc + 32'd8, e.act, e.slot}) begin
        mismatched++;
        $display("FAIL sequential[%0d]: pc=%h link=%h active=%b slot=%b, expected pc=%h active=%b slot=%b",
                 i, instr_address, link_address, active, in_delay_slot, e.pc, e.act, e.slot);
      end
    end
  endtask

  task automatic test_branch();
    step_t t[$];
    step_t e;
    do_reset();
    t.push_back(mk(1'b1, 1'b0, 1'b1, 16'h0002, 1'b0, 26'h0, 1'b0, 32'h0, RV + 32'h4, 1'b1, 1'b1));
    t.push_back(nop(RV + 32'hC, 1'b0));
    t.push_back(nop(RV + 32'h10, 1'b0));
    foreach (t[i]) begin
      apply(t[i]);
      sb.push_back(t[i]);
      tick();
      e = sb.pop_front();
      compared++;
      if ({instr_address, link_address, active, in_delay_slot} !== {e.pc, e.pc + 32'd8, e.act, e.slot}) begin
        mismatched++;
        $display("FAIL branch[%0d]: pc=%h link=%h active=%b slot=%b, expected pc=%h active=%b slot=%b",
                 i, instr_address, link_address, active, in_delay_slot, e.pc, e.act, e.slot);
      end
    end
  endtask

  task automatic test_jr_halt();
    step_t t[$];
    step_t e;
    do_reset();
    for (int k = 1; k <= 4; k++) t.push_back(nop(RV + 32'(4 * k), 1'b0));
    t.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0, RV + 32'h14, 1'b1, 1'b1));
    t.push_back(nop(32'h0, 1'b0));
    t[$].act = 1'b0;
    // Halted: enables, stalls and fresh requests must all be ignored.
    t.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
    t.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
    t.push_back(mk(1'b1, 1'b0, 1'b1, 16'h0004, 1'b0, 26'h0, 1'b1, 32'h100, 32'h0, 1'b0, 1'b0));
    t.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 26'h40, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
    foreach (t[i]) begin
      apply(t[i]);
      sb.push_back(t[i]);
      tick();
      e = sb.pop_front();
      compared++;
      if ({instr_address, link_address, active, in_delay_slot} !== {e.pc, e.pc + 32'd8, e.act, e.slot}) begin
        mismatched++;
        $display("FAIL jr_halt[%0d]: pc=%h link=%h active=%b slot=%b, expected pc=%h active=%b slot=%b",
                 i, instr_address, link_address, active, in_delay_slot, e.pc, e.act, e.slot);
      end
    end
  endtask

  task automatic test_jump_imm();
    step_t t[$];
    step_t e;
    do_reset();
    for (int k = 1; k <= 8; k++) t.push_back(nop(RV + 32'(4 * k), 1'b0));
    t.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 26'h100, 1'b0, 32'h0, RV + 32'h24, 1'b1, 1'b1));
    // Branch presented in the slot is ignored.
    t.push_back(mk(1'b1, 1'b0, 1'b1, 16'h0040, 1'b0, 26'h0, 1'b0, 32'h0, 32'hB000_0400, 1'b1, 1'b0));
    // All three requests: jump_reg wins.
    t.push_back(mk(1'b1, 1'b0, 1'b1, 16'h0005, 1'b1, 26'h3, 1'b1, 32'h1000, 32'hB000_0404, 1'b1, 1'b1));
    t.push_back(nop(32'h1000, 1'b0));
    // jump_imm beats branch_taken.
    t.push_back(mk(1'b1, 1'b0, 1'b1, 16'h0001, 1'b1, 26'h5, 1'b0, 32'h0, 32'h1004, 1'b1, 1'b1));
    t.push_back(nop(32'h14, 1'b0));
    foreach (t[i]) begin
      apply(t[i]);
      sb.push_back(t[i]);
      tick();
      e = sb.pop_front();
      compared++;
      if ({instr_address, link_address, active, in_delay_slot} !== {e.pc, e.pc + 32'd8, e.act, e.slot}) begin
        mismatched++;
        $display("FAIL jump_imm[%0d]: pc=%h link=%h active=%b slot=%b, expected pc=%h active=%b slot=%b",
                 i, instr_address, link_address, active, in_delay_slot, e.pc, e.act, e.slot);
      end
    end
  endtask

  task automatic test_stall_hold();
    step_t t[$];
    step_t e;
    do_reset();
    t.push_back(mk(1'b1, 1'b0, 1'b1, 16'h0010, 1'b0, 26'h0, 1'b0, 32'h0, RV + 32'h4, 1'b1, 1'b1));
    for (int k = 0; k < 3; k++)
      t.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0100, 1'b0, 26'h0, 1'b0, 32'h0, RV + 32'h4, 1'b1, 1'b1));
    for (int k = 0; k < 2; k++)
      t.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 26'h77, 1'b0, 32'h0, RV + 32'h4, 1'b1, 1'b1));
    t.push_back(nop(RV + 32'h44, 1'b0));
    t.push_back(nop(RV + 32'h48, 1'b0));
    foreach (t[i]) begin
      apply(t[i]);
      sb.push_back(t[i]);
      tick();
      e = sb.pop_front();
      compared++;
      if ({instr_address, link_address, active, in_delay_slot} !== {e.pc, e.pc + 32'd8, e.act, e.slot}) begin
        mismatched++;
        $display("FAIL stall_hold[%0d]: pc=%h link=%h active=%b slot=%b, expected pc=%h active=%b slot=%b",
                 i, instr_address, link_address, active, in_delay_slot, e.pc, e.act, e.slot);
      end
    end
  endtask

  task automatic test_async_reset();
    step_t t[$];
    step_t e;
    do_reset();
    apply(mk(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 26'h3FFFF, 1'b0, 32'h0, RV + 32'h4, 1'b1, 1'b1));
    tick();
    compared++;
    if ({instr_address, in_delay_slot} !== {RV + 32'h4, 1'b1}) begin
      mismatched++;
      $display("FAIL async_pre: pc=%h slot=%b, expected pc=%h slot=1", instr_address, in_delay_slot, RV + 32'h4);
    end
    idle_inputs();
    #2;
    reset = 1'b1;
    #1;
    compared++;
    if ({instr_address, link_address, active, in_delay_slot} !== {RV, RV + 32'd8, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL async_mid: pc=%h link=%h active=%b slot=%b, expected pc=%h active=1 slot=0",
               instr_address, link_address, active, in_delay_slot, RV);
    end
    @(negedge clk);
    reset = 1'b0;
    t.push_back(nop(RV + 32'h4, 1'b0));
    t.push_back(nop(RV + 32'h8, 1'b0));
    foreach (t[i]) begin
      apply(t[i]);
      sb.push_back(t[i]);
      tick();
      e = sb.pop_front();
      compared++;
      if ({instr_address, link_address, active, in_delay_slot} !== {e.pc, e.pc + 32'd8, e.act, e.slot}) begin
        mismatched++;
        $display("FAIL async_after[%0d]: pc=%h link=%h active=%b slot=%b, expected pc=%h active=%b slot=%b",
                 i, instr_address, link_address, active, in_delay_slot, e.pc, e.act, e.slot);
      end
    end
  endtask

  task automatic test_wrap();
    step_t t[$];
    step_t e;
    do_reset();
    t.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFF8, RV + 32'h4, 1'b1, 1'b1));
    t.push_back(nop(32'hFFFF_FFF8, 1'b0));
    t.push_back(nop(32'hFFFF_FFFC, 1'b0));
    // Sequential wrap to 0 keeps running.
    t.push_back(nop(32'h0, 1'b0));
    t.push_back(nop(32'h4, 1'b0));
    // Backward branch to 0: (4+4) + (-2 << 2) = 0, which halts.
    t.push_back(mk(1'b1, 1'b0, 1'b1, 16'hFFFE, 1'b0, 26'h0, 1'b0, 32'h0, 32'h8, 1'b1, 1'b1));
    t.push_back(nop(32'h0, 1'b0));
    t[$].act = 1'b0;
    foreach (t[i]) begin
      apply(t[i]);
      sb.push_back(t[i]);
      tick();
      e = sb.pop_front();
      compared++;
      if ({instr_address, link_address, active, in_delay_slot} !== {e.pc, e.pc + 32'd8, e.act, e.slot}) begin
        mismatched++;
        $display("FAIL wrap[%0d]: pc=%h link=%h active=%b slot=%b, expected pc=%h active=%b slot=%b",
                 i, instr_address, link_address, active, in_delay_slot, e.pc, e.act, e.slot);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jr_halt();
    test_jump_imm();
    test_stall_hold();
    test_async_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mips_cpu_pc_unit.md
# mips_cpu_pc_unit

Program-counter and control-flow sequencer for the Harvard MIPS core. It drives the instruction-memory address and applies taken branches and jumps with one architectural delay slot. It also signals halt when control transfers to address 0. It sits directly upstream of instruction fetch: `instr_address` feeds the instruction memory, and decode returns the branch/jump decision for the instruction currently addressed.

## Interface
- `RESET_VECTOR`, 32'hBFC00000, PC value loaded on reset.
- `HALT_ADDR`, 32'h00000000, PC value that ends execution.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `clk_enable`  in  1  global advance enable; when 0, all state holds.
- `stall`  in  1  holds the PC for a multi-cycle instruction; when 1, all state holds.
- `branch_taken`  in  1  decoded conditional branch at the current PC is taken.
- `branch_offset`  in  16  signed word offset from the branch's immediate.
- `jump_imm`  in  1  J/JAL at the current PC.
- `jump_index`  in  26  instr_index field of J/JAL.
- `jump_reg`  in  1  JR/JALR at the current PC.
- `jump_reg_value`  in  32  rs value for JR/JALR.
- `instr_address`  out  32  registered PC.
- `link_address`  out  32  combinational `instr_address + 8`, used for JAL/JALR/xxxAL.
- `active`  out  1  1 while running; 0 once halted.
- `in_delay_slot`  out  1  current PC is a delay-slot instruction.

## Operation
- States:
  - RUN: normal sequential fetch.
  - SLOT: executing the delay slot, target held in `pending_target`.
  - HALT: stopped.
- An advance occurs on a rising edge with `clk_enable`=1, `stall`=0 and state≠HALT. With no advance, the PC, state and pending target hold.
- RUN, no request: PC ← PC+4.
- RUN, request: capture the target, PC ← PC+4, go to SLOT. Target rules:
  - branch: `(PC+4) + (sext(branch_offset) << 2)`, mod 2^32.
  - jump_imm: `{(PC+4)[31:28], jump_index, 2'b00}`.
  - jump_reg: `jump_reg_value` taken verbatim, no alignment check.
- Request priority when several are asserted: `jump_reg` > `jump_imm` > `branch_taken`.
- SLOT, on advance: PC ← `pending_target`. Next state is HALT if `pending_target`==HALT_ADDR, else RUN.
- Any branch/jump request in SLOT (branch in a delay slot) is ignored; the first target wins.
- HALT: PC stays at HALT_ADDR and `active`=0 until reset; `clk_enable` and `stall` have no effect.
- PC+4 and target arithmetic wrap modulo 2^32; 32'hFFFFFFFC + 4 → 0.
- A sequential fetch that reaches 0 without a jump does not halt; only a control transfer to HALT_ADDR halts.

## Timing
- Reset, asynchronous, takes effect immediately and mid-operation:
  - `instr_address`=RESET_VECTOR, state=RUN, `pending_target`=0.
  - `active`=1, `in_delay_slot`=0, `link_address`=RESET_VECTOR+8.
  - Any pending target is discarded.
- Decode is combinational from `instr_readdata`. Request inputs are sampled at the same edge that advances past the requesting instruction.
- The target takes effect two advances after the branch's edge (delay slot in between), i.e. branch-to-target latency is 2 enabled cycles.
- `active` falls on the same edge where `instr_address` becomes HALT_ADDR.
- `in_delay_slot` is registered and equals (state==SLOT).

## Test plan
- Reset, then 3 advances with no requests → addresses BFC00000, BFC00004, BFC00008, BFC0000C; `active`=1 throughout.
- `branch_taken`=1, offset=2 at BFC00000 → next BFC00004 with `in_delay_slot`=1, then BFC0000C; BFC00008 never issued.
- JR: `jump_reg`=1, value=0 at BFC00010 → BFC00014 (slot), then 0 with `active`=0. Further edges, including toggled `clk_enable`/`stall`, leave PC=0.
- J at BFC00020 with index=0x0000100 → BFC00024, then B0000400. Second case: a `branch_taken` request presented in the slot is ignored.
- Stall/enable hold: `stall`=1 for 3 edges in SLOT, then `clk_enable`=0 for 2 edges → PC and pending target unchanged; the first free advance goes to the target.
- Async reset asserted mid-cycle while in SLOT → `instr_address`=BFC00000 before the next edge. After release, sequential fetch resumes with no stale target applied.
